// File: rtl/dtw_backtrace_engine.sv
// DTW warping-path backtracer: walks a banded direction store from (X,Y) to (0,0)
// and streams every visited point over a valid/ready handshake.
module dtw_backtrace_engine #(
    parameter  int COORD_W   = 5,
    parameter  int HALF_BAND = 5,
    localparam int LANES     = 2 * HALF_BAND + 1,
    localparam int LANE_W    = $clog2(LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [COORD_W-1:0]   start_x,
    input  logic [COORD_W-1:0]   start_y,
    input  logic                 abort,
    output logic                 busy,
    output logic                 dir_rd_en,
    output logic [COORD_W-1:0]   dir_rd_x,
    output logic [LANE_W-1:0]    dir_rd_lane,
    input  logic [1:0]           dir_rd_data,
    output logic                 pt_valid,
    input  logic                 pt_ready,
    output logic [COORD_W-1:0]   pt_x,
    output logic [COORD_W-1:0]   pt_y,
    output logic [1:0]           pt_dir,
    output logic                 pt_last,
    output logic                 done,
    output logic [COORD_W:0]     path_len,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [2:0]           dbgState
);

    // Handshake: a point transfers on every rising edge where pt_valid && pt_ready;
    // pt_x/pt_y/pt_dir/pt_last stay stable while pt_valid is high and pt_ready is low.

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, EMIT, ERR} stateT;

    localparam int SW = ((COORD_W > LANE_W) ? COORD_W : LANE_W) + 2;
    localparam logic signed [SW-1:0] HB = SW'(HALF_BAND);

    stateT state, stateNext;

    logic [COORD_W-1:0] nextX, nextY, stepX, stepY;
    logic [1:0]         nextDir, nextErrCode;
    logic               nextLast, loadPt, loadDir, setErr, clearRun, incLen, doneNext;

    function automatic logic signed [SW-1:0] diagOf(input logic [COORD_W-1:0] cx,
                                                    input logic [COORD_W-1:0] cy);
        return $signed(SW'(cy)) - $signed(SW'(cx));
    endfunction

    function automatic logic inBand(input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy);
        logic signed [SW-1:0] d;
        d = diagOf(cx, cy);
        return (d >= -HB) && (d <= HB);
    endfunction

    function automatic logic [LANE_W-1:0] laneOf(input logic [COORD_W-1:0] cx,
                                                 input logic [COORD_W-1:0] cy);
        return LANE_W'(diagOf(cx, cy) + HB);
    endfunction

    // On an edge of the matrix the only move left is along that edge, whatever the code says.
    always_comb begin
        stepX = pt_x;
        stepY = pt_y;
        if (pt_x == '0) begin
            stepY = pt_y - COORD_W'(1);
        end else if (pt_y == '0) begin
            stepX = pt_x - COORD_W'(1);
        end else begin
            if (pt_dir != 2'd2) stepX = pt_x - COORD_W'(1);
            if (pt_dir != 2'd0) stepY = pt_y - COORD_W'(1);
        end
    end

    always_comb begin
        stateNext   = state;
        nextX       = pt_x;
        nextY       = pt_y;
        nextDir     = pt_dir;
        nextLast    = pt_last;
        nextErrCode = err_code;
        loadPt      = 1'b0;
        loadDir     = 1'b0;
        setErr      = 1'b0;
        clearRun    = 1'b0;
        incLen      = 1'b0;
        doneNext    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clearRun = 1'b1;
                    loadPt   = 1'b1;
                    nextX    = start_x;
                    nextY    = start_y;
                    nextDir  = 2'd0;
                    nextLast = 1'b0;
                    if (!inBand(start_x, start_y)) begin
                        stateNext   = ERR;
                        setErr      = 1'b1;
                        nextErrCode = 2'd1;
                    end else if (start_x == '0 && start_y == '0) begin
                        stateNext = EMIT;
                        nextLast  = 1'b1;
                    end else begin
                        stateNext = READ;
                    end
                end
            end
            READ: stateNext = CAPTURE;
            CAPTURE: begin
                if (dir_rd_data == 2'd3) begin
                    stateNext   = ERR;
                    setErr      = 1'b1;
                    nextErrCode = 2'd2;
                end else begin
                    stateNext = EMIT;
                    loadDir   = 1'b1;
                    nextDir   = dir_rd_data;
                end
            end
            EMIT: begin
                if (pt_ready) begin
                    incLen = 1'b1;
                    if (pt_last) begin
                        doneNext  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        loadPt   = 1'b1;
                        nextX    = stepX;
                        nextY    = stepY;
                        nextDir  = 2'd0;
                        nextLast = 1'b0;
                        if (!inBand(stepX, stepY)) begin
                            stateNext   = ERR;
                            setErr      = 1'b1;
                            nextErrCode = 2'd1;
                        end else if (stepX == '0 && stepY == '0) begin
                            nextLast = 1'b1;
                        end else begin
                            stateNext = READ;
                        end
                    end
                end
            end
            ERR:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // Abort still lets a simultaneous acceptance count towards path_len.
        if (abort && state != IDLE) begin
            stateNext = IDLE;
            setErr    = 1'b0;
            doneNext  = 1'b0;
            loadPt    = 1'b0;
            loadDir   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            dir_rd_en   <= 1'b0;
            dir_rd_x    <= '0;
            dir_rd_lane <= '0;
            pt_valid    <= 1'b0;
            pt_x        <= '0;
            pt_y        <= '0;
            pt_dir      <= 2'd0;
            pt_last     <= 1'b0;
            done        <= 1'b0;
            path_len    <= '0;
            err         <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            state     <= stateNext;
            busy      <= (stateNext != IDLE);
            dir_rd_en <= (stateNext == READ);
            pt_valid  <= (stateNext == EMIT);
            done      <= doneNext;
            if (loadPt) begin
                pt_x    <= nextX;
                pt_y    <= nextY;
                pt_dir  <= nextDir;
                pt_last <= nextLast;
            end else if (loadDir) begin
                pt_dir <= nextDir;
            end
            if (stateNext == READ) begin
                dir_rd_x    <= nextX;
                dir_rd_lane <= laneOf(nextX, nextY);
            end
            if (clearRun) path_len <= '0;
            else if (incLen) path_len <= path_len + 1'b1;
            if (setErr) begin
                err      <= 1'b1;
                err_code <= nextErrCode;
            end else if (clearRun) begin
                err      <= 1'b0;
                err_code <= 2'd0;
            end
        end
    end

    assign dbgState = state;

endmodule

// File: tb/tb_dtw_backtrace_engine.sv
// Self-checking bench for dtw_backtrace_engine: directed corner walks plus random
// stores/starts checked against a path-following reference model.
module tb_dtw_backtrace_engine;

    localparam int COORD_W   = 5;
    localparam int HALF_BAND = 5;
    localparam int LANES     = 2 * HALF_BAND + 1;
    localparam int LANE_W    = $clog2(LANES);
    localparam int MAXC      = (1 << COORD_W) - 1;
    localparam int PW        = 2 * COORD_W + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, abort, busy, dir_rd_en, pt_valid, pt_ready;
    logic [COORD_W-1:0] start_x, start_y, dir_rd_x, pt_x, pt_y;
    logic [LANE_W-1:0]  dir_rd_lane;
    logic [1:0]         dir_rd_data, pt_dir, err_code;
    logic               pt_last, done, err;
    logic [COORD_W:0]   path_len;
    logic [2:0]         dbgState;

    dtw_backtrace_engine #(.COORD_W(COORD_W), .HALF_BAND(HALF_BAND)) dut (
        .clk(clk), .rst(rst), .start(start), .start_x(start_x), .start_y(start_y),
        .abort(abort), .busy(busy), .dir_rd_en(dir_rd_en), .dir_rd_x(dir_rd_x),
        .dir_rd_lane(dir_rd_lane), .dir_rd_data(dir_rd_data), .pt_valid(pt_valid),
        .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_dir(pt_dir), .pt_last(pt_last),
        .done(done), .path_len(path_len), .err(err), .err_code(err_code), .dbgState(dbgState)
    );

    int nChecks = 0;
    int nBad    = 0;
    logic [PW-1:0] expQ[$];
    logic [1:0] store [0:MAXC][0:LANES-1];
    int expLen, expErr, expCode, expDone;
    int doneCount, readCount, readyMode;
    int cyc;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        nChecks++;
        if (got !== want) begin
            nBad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic bit bandOk(input int x, input int y);
        return (y - x >= -HALF_BAND) && (y - x <= HALF_BAND);
    endfunction

    function automatic logic [PW-1:0] packPt(input int x, input int y, input int dir, input int last);
        return {COORD_W'(x), COORD_W'(y), 2'(dir), 1'(last)};
    endfunction

    // Reference: follow the codes cell by cell, moving along an edge once one is reached.
    task automatic buildModel(input int sx, input int sy);
        int x, y, code;
        expQ.delete();
        expLen = 0; expErr = 0; expCode = 0; expDone = 0;
        x = sx; y = sy;
        if (!bandOk(x, y)) begin
            expErr = 1; expCode = 1;
            return;
        end
        for (int step = 0; step < 200; step++) begin
            if (x == 0 && y == 0) begin
                expQ.push_back(packPt(0, 0, 0, 1));
                expLen++; expDone = 1;
                return;
            end
            code = int'(store[x][y - x + HALF_BAND]);
            if (code == 3) begin
                expErr = 1; expCode = 2;
                return;
            end
            expQ.push_back(packPt(x, y, code, 0));
            expLen++;
            if (x == 0)      y = y - 1;
            else if (y == 0) x = x - 1;
            else begin
                if (code != 2) x = x - 1;
                if (code != 0) y = y - 1;
            end
            if (!bandOk(x, y)) begin
                expErr = 1; expCode = 1;
                return;
            end
        end
    endtask

    task automatic fillStore(input int code);
        for (int x = 0; x <= MAXC; x++)
            for (int l = 0; l < LANES; l++)
                store[x][l] = (code >= 0) ? 2'(code)
                            : (($urandom_range(0, 39) == 0) ? 2'd3 : 2'($urandom_range(0, 2)));
    endtask

    // Direction store: data valid exactly in the cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (dir_rd_en && int'(dir_rd_lane) < LANES) dir_rd_data <= store[dir_rd_x][dir_rd_lane];
        else dir_rd_data <= 2'($urandom_range(0, 3));
    end

    // Consumer and scoreboard
    always @(negedge clk) begin
        logic [PW-1:0] e;
        case (readyMode)
            0:       pt_ready = 1'b1;
            1:       pt_ready = ($urandom_range(0, 3) != 0);
            default: pt_ready = 1'b0;
        endcase
        if (!rst) begin
            if (dir_rd_en) readCount++;
            if (done) begin
                doneCount++;
                checkEq("done_busy", 32'(busy), 0);
            end
            if (pt_valid && pt_ready) begin
                if (expQ.size() == 0) checkEq("extra_pt", 1, 0);
                else begin
                    e = expQ.pop_front();
                    checkEq("pt", 32'({pt_x, pt_y, pt_dir, pt_last}), 32'(e));
                end
            end
        end
    end

    task automatic startWalk(input int sx, input int sy);
        buildModel(sx, sy);
        doneCount = 0; readCount = 0;
        start_x = COORD_W'(sx); start_y = COORD_W'(sy); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finishWalk(input string tag, output int cycles);
        cycles = 0;
        while (busy && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        if (busy) begin
            checkEq({tag, "_timeout"}, 1, 0);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        @(negedge clk);
        checkEq({tag, "_left"}, 32'(expQ.size()), 0);
        checkEq({tag, "_len"}, 32'(path_len), 32'(expLen));
        checkEq({tag, "_err"}, 32'(err), 32'(expErr));
        checkEq({tag, "_code"}, 32'(err_code), 32'(expCode));
        checkEq({tag, "_done"}, 32'(doneCount), 32'(expDone));
        expQ.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkEq({tag, "_busy"}, 32'(busy), 0);
        checkEq({tag, "_rd"}, 32'(dir_rd_en), 0);
        checkEq({tag, "_valid"}, 32'(pt_valid), 0);
        checkEq({tag, "_pt"}, 32'({pt_x, pt_y, pt_dir, pt_last}), 0);
        checkEq({tag, "_done"}, 32'(done), 0);
        checkEq({tag, "_len"}, 32'(path_len), 0);
        checkEq({tag, "_err"}, 32'({err, err_code}), 0);
    endtask

    initial begin
        logic [PW-1:0] snap;
        int sx, sy, waitCnt;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start_x = '0; start_y = '0;
        readyMode = 0; pt_ready = 1'b1; doneCount = 0; readCount = 0;
        fillStore(1);
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Pure diagonal with first-point latency
        startWalk(4, 4);
        checkEq("lat_rd", 32'(dir_rd_en), 1);
        @(negedge clk);
        checkEq("lat_cap", 32'(pt_valid), 0);
        @(negedge clk);
        checkEq("lat_pt", 32'(pt_valid), 1);
        finishWalk("diag", cyc);
        checkEq("diag_len5", 32'(path_len), 5);

        // Edge clamp along Y==0
        fillStore(2);
        startWalk(3, 0);
        finishWalk("clamp", cyc);
        checkEq("clamp_len4", 32'(path_len), 4);

        // Start at (0,0)
        startWalk(0, 0);
        finishWalk("origin", cyc);

        // Band violations at the start cell
        startWalk(0, HALF_BAND + 1);
        finishWalk("band_hi", cyc);
        checkEq("band_hi_quick", 32'(cyc <= 2), 1);
        checkEq("band_hi_reads", 32'(readCount), 0);
        startWalk(HALF_BAND + 4, 2);
        finishWalk("band_lo", cyc);
        checkEq("band_lo_reads", 32'(readCount), 0);

        // Illegal code at the start cell
        fillStore(1);
        store[2][HALF_BAND] = 2'd3;
        startWalk(2, 2);
        finishWalk("illegal", cyc);
        checkEq("illegal_code2", 32'(err_code), 2);

        // Backpressure, ignored start while busy, abort
        fillStore(1);
        readyMode = 2;
        startWalk(6, 6);
        waitCnt = 0;
        while (!pt_valid && waitCnt < 10) begin
            @(negedge clk);
            waitCnt++;
        end
        snap = PW'({pt_x, pt_y, pt_dir, pt_last});
        checkEq("bp_first", 32'(snap), 32'(packPt(6, 6, 1, 0)));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkEq("bp_hold", 32'({pt_x, pt_y, pt_dir, pt_last}), 32'(snap));
            checkEq("bp_valid", 32'(pt_valid), 1);
        end
        start_x = COORD_W'(1); start_y = COORD_W'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkEq("busy_start_pt", 32'({pt_x, pt_y}), 32'({COORD_W'(6), COORD_W'(6)}));
        checkEq("busy_start_busy", 32'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkEq("abort_valid", 32'(pt_valid), 0);
        checkEq("abort_busy", 32'(busy), 0);
        @(negedge clk);
        checkEq("abort_done", 32'(doneCount), 0);
        checkEq("abort_len", 32'(path_len), 0);
        checkEq("abort_err", 32'(err), 0);
        expQ.delete();
        readyMode = 0;

        // Reset while in CAPTURE, then a fresh walk
        startWalk(5, 5);
        @(negedge clk);
        checkEq("cap_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        checkIdleOutputs("rstcap");
        rst = 1'b0;
        expQ.delete();
        @(negedge clk);
        startWalk(3, 2);
        finishWalk("after_rst", cyc);

        // Random stores, starts and backpressure
        readyMode = 1;
        for (int w = 0; w < 40; w++) begin
            fillStore(-1);
            sx = $urandom_range(0, MAXC);
            if ($urandom_range(0, 7) == 0) sy = $urandom_range(0, MAXC);
            else begin
                sy = sx + $urandom_range(0, 2 * HALF_BAND) - HALF_BAND;
                if (sy < 0) sy = 0;
                if (sy > MAXC) sy = MAXC;
            end
            startWalk(sx, sy);
            finishWalk("rand", cyc);
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
